// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel request and VGA pin bundle for vga_timing_gen
interface vga_timing_gen_if #(
  parameter int XW  = 10,
  parameter int YW  = 10,
  parameter int CDW = 4
);
  logic [XW-1:0]  pix_x;
  logic [YW-1:0]  pix_y;
  logic           pix_req;
  logic           pix_ce;
  logic [CDW-1:0] pix_r;
  logic [CDW-1:0] pix_g;
  logic [CDW-1:0] pix_b;
  logic [CDW-1:0] out_R;
  logic [CDW-1:0] out_G;
  logic [CDW-1:0] out_B;
  logic           hsync;
  logic           vsync;
  logic           line_start;
  logic           frame_start;

  modport master (
    input  pix_r, pix_g, pix_b,
    output pix_x, pix_y, pix_req, pix_ce,
    output out_R, out_G, out_B, hsync, vsync, line_start, frame_start
  );

  modport slave (
    output pix_r, pix_g, pix_b,
    input  pix_x, pix_y, pix_req, pix_ce,
    input  out_R, out_G, out_B, hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with registered pixel output stage
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CDW      = 4,
  parameter int CLK_DIV  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic [DW-1:0] div;
  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          ce;
  logic          req;
  logic          h_last;
  logic          v_last;
  logic          hs_on;
  logic          vs_on;

  // Comparisons are done at 32 bits so a sync window ending exactly at a power of two cannot alias.
  assign ce     = en && (32'(div) == CLK_DIV - 1);
  assign h_last = (32'(h_cnt) == H_TOTAL - 1);
  assign v_last = (32'(v_cnt) == V_TOTAL - 1);
  assign req    = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
  assign hs_on  = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_on  = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);

  assign bus.pix_x   = h_cnt;
  assign bus.pix_y   = v_cnt;
  assign bus.pix_req = req;
  assign bus.pix_ce  = ce;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div             <= '0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      bus.out_R       <= '0;
      bus.out_G       <= '0;
      bus.out_B       <= '0;
      bus.hsync       <= ~HS_ACT;
      bus.vsync       <= ~VS_ACT;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else if (!en) begin
      div             <= '0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      bus.out_R       <= '0;
      bus.out_G       <= '0;
      bus.out_B       <= '0;
      bus.hsync       <= ~HS_ACT;
      bus.vsync       <= ~VS_ACT;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      div             <= ce ? '0 : div + 1'b1;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
      if (ce) begin
        h_cnt <= h_last ? '0 : h_cnt + 1'b1;
        if (h_last) begin
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end
        // Blanked colour is forced to zero so undriven upstream data never reaches the pins.
        bus.out_R       <= req ? bus.pix_r : '0;
        bus.out_G       <= req ? bus.pix_g : '0;
        bus.out_B       <= req ? bus.pix_b : '0;
        bus.hsync       <= hs_on ? HS_ACT : ~HS_ACT;
        bus.vsync       <= vs_on ? VS_ACT : ~VS_ACT;
        bus.line_start  <= (h_cnt == '0) && (32'(v_cnt) < V_ACTIVE);
        bus.frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen at default and small parameter sets
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_d = 1'b0;
  logic en_p = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.XW(10), .YW(10), .CDW(4)) d_if ();
  vga_timing_gen_if #(.XW(4), .YW(3), .CDW(4)) p_if ();

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .en(en_d), .bus(d_if.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CDW(4), .CLK_DIV(1)
  ) u_par (
    .clk(clk), .rst(rst), .en(en_p), .bus(p_if.master)
  );

  // Upstream source: coordinate-derived colour in the active area, X everywhere else.
  always_comb begin
    d_if.pix_r = d_if.pix_req ? d_if.pix_x[3:0] : 4'bx;
    d_if.pix_g = d_if.pix_req ? d_if.pix_y[3:0] : 4'bx;
    d_if.pix_b = d_if.pix_req ? 4'hF : 4'bx;
    p_if.pix_r = p_if.pix_req ? p_if.pix_x : 4'bx;
    p_if.pix_g = p_if.pix_req ? {1'b0, p_if.pix_y} : 4'bx;
    p_if.pix_b = p_if.pix_req ? 4'hA : 4'bx;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int hs_fall1, hs_fall2, hs_low;
  int ls_cnt, fs_cnt, fs_first, fs_second;

  localparam logic [16:0] DEF_RST = {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] def_outs();
    return {d_if.out_R, d_if.out_G, d_if.out_B, d_if.hsync, d_if.vsync,
            d_if.line_start, d_if.frame_start, d_if.pix_ce};
  endfunction

  // Cycle i counts negedges after en/rst release; pixel n is registered on ce edge 2+2n.
  task automatic run_def(input int ncyc);
    int e, n, h, v;
    logic act;
    logic prev_hs;
    int low_start;
    logic [16:0] exp;
    prev_hs   = 1'b1;
    low_start = -1;
    hs_fall1  = -1;
    hs_fall2  = -1;
    hs_low    = -1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (i == 1) begin
        exp = {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      end else begin
        e   = i - (i % 2);
        n   = (e - 2) / 2;
        h   = n % 800;
        v   = (n / 800) % 525;
        act = (h < 640) && (v < 480);
        exp = {act ? 4'(h) : 4'h0, act ? 4'(v) : 4'h0, act ? 4'hF : 4'h0,
               !(h >= 656 && h < 752), !(v >= 490 && v < 492),
               (i == e) && (h == 0) && (v < 480), (i == e) && (h == 0) && (v == 0),
               (i % 2) == 1};
      end
      chk("def_raster", {15'h0, def_outs()}, {15'h0, exp});
      if (prev_hs && !d_if.hsync) begin
        if (hs_fall1 < 0) hs_fall1 = i;
        else if (hs_fall2 < 0) hs_fall2 = i;
        low_start = i;
      end
      if (!prev_hs && d_if.hsync && hs_low < 0) hs_low = i - low_start;
      prev_hs = d_if.hsync;
    end
  endtask

  task automatic run_par(input int ncyc);
    int n, h, v;
    logic act;
    logic [23:0] exp, got;
    ls_cnt    = 0;
    fs_cnt    = 0;
    fs_first  = -1;
    fs_second = -1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      n   = i - 1;
      h   = n % 14;
      v   = (n / 14) % 7;
      act = (h < 8) && (v < 4);
      exp = {act ? 4'(h) : 4'h0, act ? 4'(v) : 4'h0, act ? 4'hA : 4'h0,
             (h >= 10 && h < 13), (v == 5), (h == 0) && (v < 4), (h == 0) && (v == 0),
             1'b1, 4'(i % 14), 3'((i / 14) % 7)};
      got = {p_if.out_R, p_if.out_G, p_if.out_B, p_if.hsync, p_if.vsync,
             p_if.line_start, p_if.frame_start, p_if.pix_ce, p_if.pix_x, p_if.pix_y};
      chk("par_raster", {8'h0, got}, {8'h0, exp});
      if (i <= 98 && p_if.line_start) ls_cnt++;
      if (p_if.frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
    end
  endtask

  task automatic wait_xy(input int x, input int y, input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(negedge clk);
      if (d_if.pix_x == 10'(x) && d_if.pix_y == 10'(y)) found = 1'b1;
    end
    chk(tag, {31'h0, found}, 32'h1);
  endtask

  initial begin
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_def_outs", {15'h0, def_outs()}, {15'h0, DEF_RST});
    chk("rst_def_xy", {12'h0, d_if.pix_x, d_if.pix_y}, 32'h0);
    chk("rst_par_outs", {15'h0, p_if.out_R, p_if.out_G, p_if.out_B, p_if.hsync, p_if.vsync,
                         p_if.line_start, p_if.frame_start, p_if.pix_ce}, 32'h0);

    en_d = 1'b1;
    rst  = 1'b1;
    run_def(3300);
    chk("hs_fall_cycle", hs_fall1, 1314);
    chk("hs_low_clks", hs_low, 192);
    chk("hs_period_clks", hs_fall2 - hs_fall1, 1600);

    wait_xy(300, 2, "wait_300_2");
    en_d = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("en_low_outs", {15'h0, def_outs()}, {15'h0, DEF_RST});
      chk("en_low_xy", {12'h0, d_if.pix_x, d_if.pix_y}, 32'h0);
    end
    en_d = 1'b1;
    run_def(20);

    wait_xy(300, 0, "wait_300_0");
    rst = 1'b0;
    #1;
    chk("rst_mid_outs", {15'h0, def_outs()}, {15'h0, DEF_RST});
    chk("rst_mid_xy", {12'h0, d_if.pix_x, d_if.pix_y}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run_def(20);

    en_p = 1'b1;
    run_par(200);
    chk("par_line_starts", ls_cnt, 4);
    chk("par_frame_starts", fs_cnt, 3);
    chk("par_frame_period", fs_second - fs_first, 98);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
